// File: rtl/mic_volume_meter.sv
// Mic volume meter: converts 12-bit mic samples into a 4-bit LED level.
// It provides a live level (the top nibble of each sample) and a windowed
// peak-hold level with slow decay. mode_sel selects which level is output.
module mic_volume_meter #(
    parameter int unsigned WINDOW_SAMPLES = 4000,
    parameter int unsigned DECAY_WINDOWS  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] mic_in,
    input  logic        sample_valid,
    input  logic        mode_sel,
    output logic [3:0]  volume_level,
    output logic        level_valid
);

    localparam int unsigned SAMPLE_W   = 12;
    localparam int unsigned LEVEL_W    = 4;
    localparam int unsigned WIN_CNT_W  = $clog2(WINDOW_SAMPLES);
    localparam int unsigned HOLD_CNT_W = $clog2(DECAY_WINDOWS) + 1;

    localparam logic [WIN_CNT_W-1:0]  WIN_LAST  = WIN_CNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(DECAY_WINDOWS - 1);

    logic [LEVEL_W-1:0]    live_lvl;
    logic [SAMPLE_W-1:0]   win_max;
    logic [WIN_CNT_W-1:0]  win_cnt;
    logic [LEVEL_W-1:0]    peak_hold;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic                  close_q;

    logic [SAMPLE_W-1:0]   sample_max_c;
    logic [LEVEL_W-1:0]    win_lvl_c;
    logic                  close_c;
    logic [LEVEL_W-1:0]    peak_dec_c;
    logic [LEVEL_W-1:0]    peak_nxt_c;
    logic [HOLD_CNT_W-1:0] hold_nxt_c;

    // Window maximum including the current sample, and the next peak-hold state.
    always_comb begin
        sample_max_c = win_max;
        if (mic_in > win_max) begin
            sample_max_c = mic_in;
        end
        win_lvl_c  = sample_max_c[SAMPLE_W-1 -: LEVEL_W];
        close_c    = sample_valid && (win_cnt == WIN_LAST);
        peak_dec_c = (peak_hold == '0) ? '0 : peak_hold - LEVEL_W'(1);
        peak_nxt_c = peak_hold;
        hold_nxt_c = hold_cnt;
        if (close_c) begin
            if (win_lvl_c >= peak_hold) begin
                peak_nxt_c = win_lvl_c;
                hold_nxt_c = '0;
            end else if (hold_cnt == HOLD_LAST) begin
                peak_nxt_c = (peak_dec_c > win_lvl_c) ? peak_dec_c : win_lvl_c;
                hold_nxt_c = '0;
            end else begin
                hold_nxt_c = hold_cnt + HOLD_CNT_W'(1);
            end
        end
    end

    // Live level tracks the top nibble of each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_lvl <= '0;
        end else if (sample_valid) begin
            live_lvl <= mic_in[SAMPLE_W-1 -: LEVEL_W];
        end
    end

    // Window counter and running maximum; both restart when the window closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_max <= '0;
            win_cnt <= '0;
        end else if (sample_valid) begin
            if (close_c) begin
                win_max <= '0;
                win_cnt <= '0;
            end else begin
                win_max <= sample_max_c;
                win_cnt <= win_cnt + WIN_CNT_W'(1);
            end
        end
    end

    // Peak hold with decay, plus a close flag that lines level_valid up with the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_hold <= '0;
            hold_cnt  <= '0;
            close_q   <= 1'b0;
        end else begin
            peak_hold <= peak_nxt_c;
            hold_cnt  <= hold_nxt_c;
            close_q   <= close_c;
        end
    end

    // Output register: the selected level and the window-close pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            volume_level <= '0;
            level_valid  <= 1'b0;
        end else begin
            volume_level <= mode_sel ? peak_hold : live_lvl;
            level_valid  <= close_q;
        end
    end

endmodule

// File: tb/tb_mic_volume_meter.sv
// Self-checking bench for mic_volume_meter, using a window-list reference model.
module tb_mic_volume_meter;

    localparam int unsigned WIN   = 4;
    localparam int unsigned DECAY = 2;

    logic        clk;
    logic        rst_n;
    logic [11:0] mic_in;
    logic        sample_valid;
    logic        mode_sel;
    logic [3:0]  volume_level;
    logic        level_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_live;
    int m_peak;
    int m_lower;
    int m_win[$];
    bit m_close_pend;
    int m_vol;
    bit m_lv;

    mic_volume_meter #(.WINDOW_SAMPLES(WIN), .DECAY_WINDOWS(DECAY)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mic_in       (mic_in),
        .sample_valid (sample_valid),
        .mode_sel     (mode_sel),
        .volume_level (volume_level),
        .level_valid  (level_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_live = 0; m_peak = 0; m_lower = 0;
        m_win.delete();
        m_close_pend = 0; m_vol = 0; m_lv = 0;
    endtask

    // One clock edge of the model: the output shows the levels held before the edge.
    task automatic model_edge(input bit v, input int s, input bit m);
        int new_vol;
        bit new_lv;
        int mx;
        int wl;
        new_vol = m ? m_peak : m_live;
        new_lv  = m_close_pend;
        m_close_pend = 0;
        if (v) begin
            m_live = s / 256;
            m_win.push_back(s);
            if (m_win.size() == WIN) begin
                mx = 0;
                foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
                wl = mx / 256;
                if (wl >= m_peak) begin
                    m_peak = wl;
                    m_lower = 0;
                end else begin
                    m_lower++;
                    if (m_lower == DECAY) begin
                        m_peak = (m_peak - 1 > wl) ? m_peak - 1 : wl;
                        m_lower = 0;
                    end
                end
                m_win.delete();
                m_close_pend = 1;
            end
        end
        m_vol = new_vol;
        m_lv  = new_lv;
    endtask

    // Drive one cycle from a negedge, then compare at the following negedge.
    task automatic step(input bit v, input logic [11:0] s, input bit m);
        sample_valid = v;
        mic_in       = s;
        mode_sel     = m;
        @(posedge clk);
        model_edge(v, int'(s), m);
        @(negedge clk);
        n_vec++;
        if (volume_level !== 4'(m_vol)) begin
            n_err++;
            $display("FAIL model_vol t=%0t got=%0d want=%0d", $time, volume_level, m_vol);
        end
        n_vec++;
        if (level_valid !== m_lv) begin
            n_err++;
            $display("FAIL model_lv t=%0t got=%0b want=%0b", $time, level_valid, m_lv);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_valid = 1'b0; mic_in = '0; mode_sel = 1'b0;
        model_reset();
        #12;
        n_vec++;
        if (volume_level !== 4'd0 || level_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got=%0d/%0b want=0/0", volume_level, level_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 12'h000, 0);
    endtask

    task automatic test_live_map();
        logic [11:0] smp[4];
        int exp_lvl[4];
        smp = '{12'h0FF, 12'h100, 12'h7FF, 12'hFFF};
        exp_lvl = '{0, 1, 7, 15};
        for (int i = 0; i < 4; i++) begin
            step(1, smp[i], 0);
            step(0, 12'h000, 0);
            n_vec++;
            if (volume_level !== 4'(exp_lvl[i])) begin
                n_err++;
                $display("FAIL live_map[%0d] got=%0d want=%0d", i, volume_level, exp_lvl[i]);
            end
        end
    endtask

    task automatic test_window_peak();
        logic [11:0] smp[4];
        int pulses;
        smp = '{12'h200, 12'h9A0, 12'h300, 12'h100};
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, smp[i], 1);
            if (level_valid) pulses++;
        end
        step(0, 12'h000, 1);
        if (level_valid) pulses++;
        n_vec++;
        if (volume_level !== 4'd9) begin
            n_err++;
            $display("FAIL window_peak got=%0d want=9", volume_level);
        end
        step(0, 12'h000, 1);
        if (level_valid) pulses++;
        n_vec++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL window_pulse_count got=%0d want=1", pulses);
        end
    endtask

    // Run one full window of mode 1 samples with the given maximum, then check the peak.
    task automatic window_and_check(input logic [11:0] mx, input int exp_peak, input string nm);
        step(1, mx, 1);
        step(1, 12'h000, 1);
        step(1, mx >> 1, 1);
        step(1, mx, 1);
        step(0, 12'h000, 1);
        n_vec++;
        if (volume_level !== 4'(exp_peak) || level_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s got=%0d/%0b want=%0d/1", nm, volume_level, level_valid, exp_peak);
        end
    endtask

    task automatic test_decay();
        window_and_check(12'h1FF, 9, "decay_w1");
        window_and_check(12'h1FF, 8, "decay_w2");
        window_and_check(12'h1FF, 8, "decay_w3");
        window_and_check(12'h1FF, 7, "decay_w4");
        window_and_check(12'h8FF, 8, "floor_w1");
        window_and_check(12'h8FF, 8, "floor_w2");
        window_and_check(12'h8FF, 8, "floor_w3");
    endtask

    task automatic test_last_sample();
        apply_reset();
        step(1, 12'h000, 1);
        step(1, 12'h000, 1);
        step(1, 12'h000, 1);
        step(1, 12'hFFF, 1);
        step(0, 12'h000, 1);
        n_vec++;
        if (volume_level !== 4'd15) begin
            n_err++;
            $display("FAIL last_sample got=%0d want=15", volume_level);
        end
        window_and_check(12'h100, 15, "restart_w1");
        window_and_check(12'h100, 14, "restart_w2");
    endtask

    task automatic test_gaps();
        int pulse_at;
        apply_reset();
        pulse_at = -1;
        for (int i = 0; i < 12; i++) begin
            step((i % 3) == 0, 12'(16'h0500 + i), 1);
            if (level_valid) pulse_at = (pulse_at < 0) ? i : 99;
        end
        n_vec++;
        if (pulse_at != 10) begin
            n_err++;
            $display("FAIL gaps_pulse_step got=%0d want=10", pulse_at);
        end
    endtask

    task automatic test_reset_mid_window();
        apply_reset();
        step(1, 12'hFFF, 0);
        step(1, 12'hFFF, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (volume_level !== 4'd0 || level_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got=%0d/%0b want=0/0", volume_level, level_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        window_and_check(12'h300, 3, "post_reset_peak");
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)),
                 (i < 200) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0));
        end
    endtask

    initial begin
        test_reset();
        test_live_map();
        test_window_peak();
        test_decay();
        test_last_sample();
        test_gaps();
        test_reset_mid_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the clocked sequence ever stalls.
    initial begin
        #1000000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
